// File: rtl/uart_pkg.sv
// Shared UART definitions.
//  - Parity-mode constants selecting none / odd / even parity.
//  - Frame FSM state encoding, shared by transmitter and receiver.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO feeding the UART transmit shifter.
// Ports:
//  clk_50m    in   system clock
//  rst_n      in   asynchronous active-low reset (pointers/count only)
//  i_wr_en    in   push request; ignored while full
//  i_wr_data  in   word to push
//  i_rd_en    in   pop request; ignored while empty
//  o_rd_data  out  word at the head of the FIFO (valid while not empty)
//  o_empty    out  FIFO holds no words
//  o_full     out  FIFO holds DEPTH words
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // Full is judged on the registered count, so a write while full is
  // dropped even when a pop happens in the same cycle.
  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_push    = i_wr_en & ~o_full;
  assign w_pop     = i_rd_en & ~o_empty;
  assign o_rd_data = r_mem[r_rd_ptr];

  // Storage carries no reset: a reset only discards the contents logically.
  always_ff @(posedge clk_50m) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO. Frame: start bit, DATA_BITS data bits
// LSB first, optional parity bit, STOP_BITS stop bits. Bit timing comes from
// the one-cycle clken baud strobe.
// Ports:
//  clk_50m    in   system clock
//  rst_n      in   asynchronous active-low reset
//  din        in   word to transmit, sampled when wr_en=1
//  wr_en      in   push din into the FIFO
//  clken      in   baud tick, once per bit period
//  tx         out  serial output, idle high
//  tx_busy    out  FIFO non-empty or frame in flight
//  fifo_full  out  FIFO holds FIFO_DEPTH words
//  overflow   out  one-cycle pulse: a write arrived while full and was dropped
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 wr_en,
  input  logic                 clken,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 fifo_full,
  output logic                 overflow
);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9 ||
        (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) ||
        (STOP_BITS != 1 && STOP_BITS != 2) ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
      $error("uart_tx_fifo: illegal parameter combination");
    end
  endgenerate

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  uart_state_t          r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [BW-1:0]        r_bitpos;
  logic                 r_stopcnt;
  logic                 r_tx;
  logic                 r_overflow;

  logic [DATA_BITS-1:0] w_fifo_data;
  logic                 w_fifo_empty;
  logic                 w_fifo_full;
  logic                 w_pop;

  // The shifter is loaded straight from the show-ahead head in IDLE.
  assign w_pop = (r_state == ST_IDLE) & ~w_fifo_empty;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_50m   (clk_50m),
    .rst_n     (rst_n),
    .i_wr_en   (wr_en),
    .i_wr_data (din),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_data),
    .o_empty   (w_fifo_empty),
    .o_full    (w_fifo_full)
  );

  // Every non-IDLE state acts only on clken. After the last stop bit the
  // FSM passes through IDLE for a cycle, so the next start bit always waits
  // for a fresh clken and the stop time is never shortened.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bitpos   <= '0;
      r_stopcnt  <= 1'b0;
      r_tx       <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= wr_en & w_fifo_full;
      case (r_state)
        ST_IDLE: begin
          if (!w_fifo_empty) begin
            r_shift   <= w_fifo_data;
            r_bitpos  <= '0;
            r_stopcnt <= 1'b0;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          if (clken) begin
            r_tx    <= 1'b0;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (clken) begin
            r_tx <= r_shift[r_bitpos];
            if (r_bitpos == LAST_BIT) begin
              r_state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              r_bitpos <= r_bitpos + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (clken) begin
            r_tx    <= (PARITY == PAR_EVEN) ? ^r_shift : ~^r_shift;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (clken) begin
            r_tx <= 1'b1;
            if (r_stopcnt == STOP_LAST) begin
              r_stopcnt <= 1'b0;
              r_state   <= ST_IDLE;
            end else begin
              r_stopcnt <= r_stopcnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx        = r_tx;
  assign overflow  = r_overflow;
  assign fifo_full = w_fifo_full;
  assign tx_busy   = (r_state != ST_IDLE) | ~w_fifo_empty;

endmodule
